// File: rtl/regfile_write_demux_if.sv
// Write-port bundle for regfile_write_demux: writeback request in, register bank,
// pending-stage forward view and error flag out.
interface regfile_write_demux_if #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5
);
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]          wr_data;
  logic [NUM_REGS*WIDTH-1:0] reg_q;
  logic [NUM_REGS-1:0]       wr_onehot;
  logic                      pend_valid;
  logic [ADDR_W-1:0]         pend_addr;
  logic [WIDTH-1:0]          pend_data;
  logic                      oob_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  reg_q, wr_onehot, pend_valid, pend_addr, pend_data, oob_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output reg_q, wr_onehot, pend_valid, pend_addr, pend_data, oob_err
  );
endinterface

// File: rtl/regfile_write_demux.sv
// Register-file write side: request -> pending stage -> one-hot decoded commit.
// Optional macro ZERO_REG_EN hardwires register NUM_REGS-1 to zero.
module regfile_write_demux #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5
) (
  input logic                  clk,
  input logic                  reset,
  regfile_write_demux_if.slave bus
);

`ifdef ZERO_REG_EN
  localparam int NUM_STORED = NUM_REGS - 1;
`else
  localparam int NUM_STORED = NUM_REGS;
`endif

  logic                      r_pend_valid;
  logic [ADDR_W-1:0]         r_pend_addr;
  logic [WIDTH-1:0]          r_pend_data;
  logic                      r_oob_err;
  logic [NUM_REGS-1:0]       w_onehot;
  logic                      w_oob;
  logic [NUM_REGS*WIDTH-1:0] w_reg_q;

  // Pending stage: captures each request; address/data hold while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else begin
      r_pend_valid <= bus.wr_en;
      if (bus.wr_en) begin
        r_pend_addr <= bus.wr_addr;
        r_pend_data <= bus.wr_data;
      end else begin
        r_pend_addr <= r_pend_addr;
        r_pend_data <= r_pend_data;
      end
    end
  end

  // Decode the pending write; a hardwired-zero register never gets a select bit
  always_comb begin
    w_onehot = '0;
    w_oob    = 1'b0;
    for (int i = 0; i < NUM_STORED; i++) begin
      if (r_pend_valid && (r_pend_addr == ADDR_W'(i))) begin
        w_onehot[i] = 1'b1;
      end else begin
        w_onehot[i] = 1'b0;
      end
    end
    if (r_pend_valid && (32'(r_pend_addr) >= 32'(NUM_REGS))) begin
      w_oob = 1'b1;
    end else begin
      w_oob = 1'b0;
    end
  end

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_oob_err <= 1'b0;
    end else if (w_oob) begin
      r_oob_err <= 1'b1;
    end else begin
      r_oob_err <= r_oob_err;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g < NUM_STORED) begin : g_flop
      logic [WIDTH-1:0] r_q;

      // Commit stage: register loads the pending data when selected
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_q <= '0;
        end else if (w_onehot[g]) begin
          r_q <= r_pend_data;
        end else begin
          r_q <= r_q;
        end
      end

      assign w_reg_q[g*WIDTH +: WIDTH] = r_q;
    end else begin : g_zero
      assign w_reg_q[g*WIDTH +: WIDTH] = '0;
    end
  end

  assign bus.reg_q      = w_reg_q;
  assign bus.wr_onehot  = w_onehot;
  assign bus.pend_valid = r_pend_valid;
  assign bus.pend_addr  = r_pend_addr;
  assign bus.pend_data  = r_pend_data;
  assign bus.oob_err    = r_oob_err;

endmodule

// File: tb/tb_regfile_write_demux.sv
// Bench for regfile_write_demux: a 32-register and a 24-register instance share
// stimulus; directed cases pin the model, then randomized traffic is scored.
module tb_regfile_write_demux;
  localparam int W  = 64;
  localparam int AW = 5;
  localparam int NA = 32;
  localparam int NB = 24;
`ifdef ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  always #5 clk = ~clk;

  regfile_write_demux_if #(.NUM_REGS(NA), .WIDTH(W), .ADDR_W(AW)) bus_a ();
  regfile_write_demux_if #(.NUM_REGS(NB), .WIDTH(W), .ADDR_W(AW)) bus_b ();

  assign bus_a.wr_en   = wr_en;
  assign bus_a.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;
  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;

  regfile_write_demux #(.NUM_REGS(NA), .WIDTH(W), .ADDR_W(AW)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  regfile_write_demux #(.NUM_REGS(NB), .WIDTH(W), .ADDR_W(AW)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  // Reference model: the bank contents, the write awaiting commit, sticky flags.
  logic [63:0]   m_reg [2][32];
  logic          m_pv;
  logic [AW-1:0] m_pa;
  logic [63:0]   m_pd;
  logic [1:0]    m_oob;

  function automatic int nregs(input int k);
    return (k == 0) ? NA : NB;
  endfunction

  function automatic bit hardwired(input int k, input int a);
    return ZERO_EN && (a == nregs(k) - 1);
  endfunction

  function automatic logic [63:0] exp_onehot(input int k);
    logic [63:0] r;
    r = 64'd0;
    if (m_pv && (int'(m_pa) < nregs(k)) && !hardwired(k, int'(m_pa))) r[m_pa] = 1'b1;
    return r;
  endfunction

  // A write issued at one edge lands in the bank at the next edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) m_reg[k][i] <= 64'd0;
      m_pv  <= 1'b0;
      m_pa  <= '0;
      m_pd  <= 64'd0;
      m_oob <= 2'b00;
    end else begin
      if (m_pv) begin
        for (int k = 0; k < 2; k++) begin
          if (int'(m_pa) >= nregs(k)) m_oob[k] <= 1'b1;
          else if (!hardwired(k, int'(m_pa))) m_reg[k][m_pa] <= m_pd;
        end
      end
      m_pv <= wr_en;
      if (wr_en) begin
        m_pa <= wr_addr;
        m_pd <= wr_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_pend_valid", 64'(bus_a.pend_valid), 64'(m_pv));
      chk("b_pend_valid", 64'(bus_b.pend_valid), 64'(m_pv));
      if (m_pv) begin
        chk("a_pend_addr", 64'(bus_a.pend_addr), 64'(m_pa));
        chk("b_pend_addr", 64'(bus_b.pend_addr), 64'(m_pa));
        chk("a_pend_data", bus_a.pend_data, m_pd);
        chk("b_pend_data", bus_b.pend_data, m_pd);
      end
      chk("a_onehot", 64'(bus_a.wr_onehot), exp_onehot(0));
      chk("b_onehot", 64'(bus_b.wr_onehot), exp_onehot(1));
      chk("a_oob", 64'(bus_a.oob_err), 64'(m_oob[0]));
      chk("b_oob", 64'(bus_b.oob_err), 64'(m_oob[1]));
      for (int i = 0; i < NA; i++)
        chk($sformatf("a_reg%0d", i), bus_a.reg_q[i*W +: W], m_reg[0][i]);
      for (int i = 0; i < NB; i++)
        chk($sformatf("b_reg%0d", i), bus_b.reg_q[i*W +: W], m_reg[1][i]);
    end
  end

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [63:0] d);
    @(negedge clk);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  logic [NA*W-1:0] exp_a;
  logic [NB*W-1:0] snap_b;
  logic [AW-1:0]   prev_addr;

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;

    // Reset then idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_regq_nonzero", 64'(bus_a.reg_q != '0), 64'd0);
    chk("rst_pend_valid", 64'(bus_a.pend_valid), 64'd0);
    chk("rst_onehot", 64'(bus_a.wr_onehot), 64'd0);
    chk("rst_oob", 64'(bus_a.oob_err), 64'd0);

    // Single write, latency one edge to pending, two to the bank
    drive(1'b1, 5'd5, 64'hDEADBEEF_00000005);
    @(posedge clk); #1;
    chk("w5_pend_valid", 64'(bus_a.pend_valid), 64'd1);
    chk("w5_pend_addr", 64'(bus_a.pend_addr), 64'd5);
    chk("w5_onehot", 64'(bus_a.wr_onehot), 64'h20);
    chk("w5_reg5_early", bus_a.reg_q[5*W +: W], 64'd0);
    drive(1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("w5_reg5", bus_a.reg_q[5*W +: W], 64'hDEADBEEF_00000005);
    exp_a = '0;
    exp_a[5*W +: W] = 64'hDEADBEEF_00000005;
    chk("w5_others_differ", 64'(bus_a.reg_q != exp_a), 64'd0);

    // Back-to-back, same address then a new one
    drive(1'b1, 5'd3, 64'h11);
    @(posedge clk); #1;
    chk("b2b_pv1", 64'(bus_a.pend_valid), 64'd1);
    drive(1'b1, 5'd3, 64'h22);
    @(posedge clk); #1;
    chk("b2b_pv2", 64'(bus_a.pend_valid), 64'd1);
    chk("b2b_reg3_first", bus_a.reg_q[3*W +: W], 64'h11);
    drive(1'b1, 5'd4, 64'h33);
    @(posedge clk); #1;
    chk("b2b_pv3", 64'(bus_a.pend_valid), 64'd1);
    chk("b2b_reg3_second", bus_a.reg_q[3*W +: W], 64'h22);
    drive(1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("b2b_reg3", bus_a.reg_q[3*W +: W], 64'h22);
    chk("b2b_reg4", bus_a.reg_q[4*W +: W], 64'h33);
    chk("b2b_pv_idle", 64'(bus_a.pend_valid), 64'd0);

    // Out-of-range on the 24-register instance
    snap_b = bus_b.reg_q;
    drive(1'b1, 5'd30, 64'hFF);
    @(posedge clk); #1;
    chk("oob_onehot_b", 64'(bus_b.wr_onehot), 64'd0);
    chk("oob_not_yet", 64'(bus_b.oob_err), 64'd0);
    drive(1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("oob_set_b", 64'(bus_b.oob_err), 64'd1);
    chk("oob_regq_changed_b", 64'(bus_b.reg_q != snap_b), 64'd0);
    chk("oob_a_clear", 64'(bus_a.oob_err), 64'd0);
    chk("a_reg30", bus_a.reg_q[30*W +: W], 64'hFF);
    drive(1'b1, 5'd2, 64'h55);
    drive(1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("oob_sticky_b", 64'(bus_b.oob_err), 64'd1);
    chk("b_reg2", bus_b.reg_q[2*W +: W], 64'h55);

    // Top register: hardwired zero only when the option is built in
    drive(1'b1, 5'd31, 64'hABCD);
    @(posedge clk); #1;
    chk("r31_pend_data", bus_a.pend_data, 64'hABCD);
    chk("r31_onehot", 64'(bus_a.wr_onehot), ZERO_EN ? 64'd0 : 64'h8000_0000);
    drive(1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    chk("r31_value", bus_a.reg_q[31*W +: W], ZERO_EN ? 64'd0 : 64'hABCD);
    chk("r31_oob", 64'(bus_a.oob_err), 64'd0);

    // Asynchronous reset lands between request and commit
    drive(1'b1, 5'd7, 64'h77);
    @(posedge clk); #3;
    reset = 1'b1;
    wr_en = 1'b0;
    #1;
    chk("arst_pv_drop", 64'(bus_a.pend_valid), 64'd0);
    chk("arst_oob_b", 64'(bus_b.oob_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("arst_reg7", bus_a.reg_q[7*W +: W], 64'd0);

    // Randomized traffic with occasional address repeats and reset pulses
    prev_addr = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_addr = ($urandom_range(0, 3) == 0) ? prev_addr : AW'($urandom_range(0, 31));
      wr_data = {$urandom(), $urandom()};
      prev_addr = wr_addr;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
